// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 frame sequencer: FSM states,
// screen codes and the RGB565 solid-colour map.
package ili9341_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } state_e;

  localparam int unsigned OUT_W = 240;
  localparam int unsigned OUT_H = 240;

  localparam int unsigned SCREEN_SPRITE = 0;
  localparam int unsigned SCREEN_LAST   = 13;

  localparam logic [15:0] COLOUR_CYAN    = 16'h07FF;
  localparam logic [15:0] COLOUR_RED     = 16'hF800;
  localparam logic [15:0] COLOUR_PURPLE  = 16'h780F;
  localparam logic [15:0] COLOUR_BLACK   = 16'h0000;
  localparam logic [15:0] COLOUR_DEFAULT = 16'h001F;

  // Screens 1..13 cycle through a four-entry map; anything else is the default.
  function automatic logic [15:0] screen_colour(input logic [31:0] sel);
    logic [31:0] idx;
    logic [15:0] c;
    idx = sel - 32'd1;
    c   = COLOUR_DEFAULT;
    if (sel != SCREEN_SPRITE && sel <= SCREEN_LAST) begin
      case (idx[1:0])
        2'd0:    c = COLOUR_CYAN;
        2'd1:    c = COLOUR_RED;
        2'd2:    c = COLOUR_PURPLE;
        default: c = COLOUR_BLACK;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ili9341_scale_counter.sv
// Raster position counters for a SCALE x nearest-neighbour upscale; produces
// the sprite ROM address of the current output pixel using adds only.
module ili9341_scale_counter #(
  parameter int SRC_W = 80,
  parameter int SRC_H = 80,
  parameter int SCALE = 3,
  parameter int AW    = $clog2(SRC_W * SRC_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  localparam int OUT_W = SRC_W * SCALE;
  localparam int OUT_H = SRC_H * SCALE;
  localparam int OXW   = $clog2(OUT_W);
  localparam int OYW   = $clog2(OUT_H);
  localparam int RW    = $clog2(SCALE);
  localparam int SXW   = $clog2(SRC_W);

  logic [OXW-1:0] r_out_x;
  logic [OYW-1:0] r_out_y;
  logic [RW-1:0]  r_rep_x;
  logic [RW-1:0]  r_rep_y;
  logic [SXW-1:0] r_src_x;
  logic [AW-1:0]  r_row_base;

  logic w_x_wrap, w_y_wrap, w_rx_wrap, w_ry_wrap;

  assign w_x_wrap  = (r_out_x == OXW'(OUT_W - 1));
  assign w_y_wrap  = (r_out_y == OYW'(OUT_H - 1));
  assign w_rx_wrap = (r_rep_x == RW'(SCALE - 1));
  assign w_ry_wrap = (r_rep_y == RW'(SCALE - 1));

  assign o_addr = r_row_base + AW'(r_src_x);
  assign o_last = w_x_wrap && w_y_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_x    <= '0;
      r_out_y    <= '0;
      r_rep_x    <= '0;
      r_rep_y    <= '0;
      r_src_x    <= '0;
      r_row_base <= '0;
    end else if (i_clr) begin
      r_out_x    <= '0;
      r_out_y    <= '0;
      r_rep_x    <= '0;
      r_rep_y    <= '0;
      r_src_x    <= '0;
      r_row_base <= '0;
    end else if (i_adv) begin
      if (w_x_wrap) begin
        r_out_x <= '0;
        r_rep_x <= '0;
        r_src_x <= '0;
        r_out_y <= w_y_wrap ? '0 : r_out_y + OYW'(1);
        // Every SCALE output rows the source row advances by one sprite line.
        if (w_ry_wrap) begin
          r_rep_y    <= '0;
          r_row_base <= w_y_wrap ? '0 : r_row_base + AW'(SRC_W);
        end else begin
          r_rep_y <= r_rep_y + RW'(1);
        end
      end else begin
        r_out_x <= r_out_x + OXW'(1);
        if (w_rx_wrap) begin
          r_rep_x <= '0;
          r_src_x <= r_src_x + SXW'(1);
        end else begin
          r_rep_x <= r_rep_x + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ili9341_frame_sequencer.sv
// Produces one full upscaled-sprite or solid-colour frame per screen change,
// applying screen changes only at frame boundaries.
module ili9341_frame_sequencer
  import ili9341_pkg::*;
#(
  parameter int SRC_W      = 80,
  parameter int SRC_H      = 80,
  parameter int SCALE      = 3,
  parameter int PIXEL_SIZE = 16,
  parameter int SEL_W      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SEL_W-1:0]                 visua,
  input  logic                             pix_ready,
  output logic                             pix_valid,
  output logic [PIXEL_SIZE-1:0]            pix_data,
  output logic                             mem_rd_en,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   mem_addr,
  input  logic [PIXEL_SIZE-1:0]            mem_rdata,
  output logic                             frame_start,
  output logic                             frame_done,
  output logic                             busy,
  output state_e                           o_dbg_state
);

  localparam int AW = $clog2(SRC_W * SRC_H);

  state_e                r_state, w_next;
  logic [SEL_W-1:0]      r_sel_q, r_active_sel;
  logic                  r_pending, r_frame_start, r_frame_done;
  logic [PIXEL_SIZE-1:0] r_pix_data;

  logic          w_latch, w_launch, w_adv, w_capture, w_last, w_sprite;
  logic [AW-1:0] w_addr;

  assign w_sprite = (r_active_sel == '0);

  ili9341_scale_counter #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .SCALE (SCALE),
    .AW    (AW)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_latch),
    .i_adv  (w_adv),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  // Handshake: pix_valid/pix_data are held until a cycle with pix_valid &
  // pix_ready; only that cycle counts as a transfer and advances the raster.
  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_launch  = 1'b0;
    w_adv     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // Latch the new screen first; the following cycle launches the frame.
        if (r_frame_start) begin
          w_launch = 1'b1;
          w_next   = w_sprite ? ST_FETCH : ST_PRESENT;
        end else if (r_pending) begin
          w_latch = 1'b1;
        end
      end
      ST_FETCH: w_next = ST_WAIT;
      ST_WAIT: begin
        w_capture = 1'b1;
        w_next    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (pix_ready) begin
          w_adv = 1'b1;
          if (w_last)        w_next = ST_DONE;
          else if (w_sprite) w_next = ST_FETCH;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_sel_q       <= '0;
      r_pending     <= 1'b1;
      r_active_sel  <= '0;
      r_pix_data    <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_sel_q       <= visua;
      r_frame_start <= w_latch;
      if (w_latch)                r_pending <= 1'b0;
      else if (visua != r_sel_q)  r_pending <= 1'b1;
      if (w_latch) begin
        r_active_sel <= visua;
        r_frame_done <= 1'b0;
      end else if (w_adv && w_last) begin
        r_frame_done <= 1'b1;
      end
      if (w_capture)
        r_pix_data <= mem_rdata;
      else if (w_launch && !w_sprite)
        r_pix_data <= PIXEL_SIZE'(screen_colour(32'(r_active_sel)));
    end
  end

  assign pix_valid   = (r_state == ST_PRESENT);
  assign pix_data    = r_pix_data;
  assign mem_rd_en   = (r_state == ST_FETCH);
  assign mem_addr    = w_addr;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_dbg_state = r_state;

endmodule
